// File: rtl/lfo_pkg.sv
// Shared types and table helper for the quadrature LFO phasor generator.
package lfo_pkg;

   localparam int C_PHASE_WIDTH    = 32;
   localparam int C_LUT_ADDR_WIDTH = 8;
   localparam int C_DOUT_WIDTH     = 16;
   localparam int C_AMPLITUDE      = 32767;
   localparam int C_LUT_N          = 2 ** C_LUT_ADDR_WIDTH;
   localparam real C_PI            = 3.14159265358979323846;

   typedef enum logic [2:0] {
      SM_INIT        = 3'd0,
      SM_ADDR        = 3'd1,
      SM_LUT         = 3'd2,
      SM_MAP         = 3'd3,
      SM_SEND_OUTPUT = 3'd4
   } state_t;

   typedef logic [1:0] quadrant_t;

   // round(amplitude * sin(pi/2 * k/n)); the argument never exceeds pi/2 so the
   // value is non-negative and +0.5 then truncation rounds to nearest.
   function automatic int lut_entry(input int k, input int n, input int amplitude);
      real x;
      x = real'(amplitude) * $sin(C_PI / 2.0 * real'(k) / real'(n));
      return $rtoi(x + 0.5);
   endfunction

endpackage

// File: rtl/lfo_quarter_lut.sv
// Quarter-wave sine ROM with two registered read ports (N+1 entries, 1-cycle latency).
module lfo_quarter_lut
   import lfo_pkg::*;
#(
   parameter int G_LUT_ADDR_WIDTH = 8,
   parameter int G_DOUT_WIDTH     = 16,
   parameter int G_AMPLITUDE      = 32767
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [G_LUT_ADDR_WIDTH:0]   addr_a,
   input  logic [G_LUT_ADDR_WIDTH:0]   addr_b,
   output logic [G_DOUT_WIDTH-1:0]     data_a,
   output logic [G_DOUT_WIDTH-1:0]     data_b
);

   localparam int N = 2 ** G_LUT_ADDR_WIDTH;

   logic [G_DOUT_WIDTH-1:0] table_s [0:N];
   logic [G_DOUT_WIDTH-1:0] data_a_r;
   logic [G_DOUT_WIDTH-1:0] data_b_r;

   for (genvar k = 0; k <= N; k++) begin : g_table
      assign table_s[k] = G_DOUT_WIDTH'(lut_entry(k, N, G_AMPLITUDE));
   end

   // Registered read of both ports.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_a_r <= '0;
         data_b_r <= '0;
      end else begin
         data_a_r <= table_s[addr_a];
         data_b_r <= table_s[addr_b];
      end
   end

   assign data_a = data_a_r;
   assign data_b = data_b_r;

endmodule

// File: rtl/lfo_phasor_gen.sv
// Quadrature LFO: phase accumulator + quarter-wave table, valid/ready output.
// Optional phase dithering is compiled in with LFO_PHASOR_DITHER_EN.
module lfo_phasor_gen
   import lfo_pkg::*;
#(
   parameter int G_PHASE_WIDTH    = 32,
   parameter int G_LUT_ADDR_WIDTH = 8,
   parameter int G_DOUT_WIDTH     = 16,
   parameter int G_AMPLITUDE      = 32767
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [G_PHASE_WIDTH-1:0] phase_inc,
   input  logic                     sync_clear,
   output logic [G_DOUT_WIDTH-1:0]  dout_re,
   output logic [G_DOUT_WIDTH-1:0]  dout_im,
   output logic                     dout_valid,
   input  logic                     dout_ready
);

   localparam int N        = 2 ** G_LUT_ADDR_WIDTH;
   localparam int AW       = G_LUT_ADDR_WIDTH + 1;
   localparam int IDX_W    = G_LUT_ADDR_WIDTH + 2;
   localparam int DITHER_W = G_PHASE_WIDTH - IDX_W;
   localparam logic [AW-1:0] C_N_ADDR = AW'(N);

   state_t                            state_r, state_nxt;
   logic [G_PHASE_WIDTH-1:0]          phase_r, phase_nxt;
   logic [G_PHASE_WIDTH-1:0]          phase_dith_s;
   logic [IDX_W-1:0]                  idx_s;
   logic [AW-1:0]                     sin_addr_r, sin_addr_nxt;
   logic [AW-1:0]                     cos_addr_r, cos_addr_nxt;
   quadrant_t                         quad_r, quad_nxt;
   logic signed [G_DOUT_WIDTH-1:0]    re_r, re_nxt;
   logic signed [G_DOUT_WIDTH-1:0]    im_r, im_nxt;
   logic                              valid_r, valid_nxt;
   logic signed [G_DOUT_WIDTH-1:0]    t_sin_s;
   logic signed [G_DOUT_WIDTH-1:0]    t_cos_s;
   logic                              accept_s;

   assign accept_s = valid_r & dout_ready;

`ifdef LFO_PHASOR_DITHER_EN
   logic [15:0]              lfsr_r;
   logic [15:0]              lfsr_step_s;
   logic [G_PHASE_WIDTH-1:0] dither_s;

   // Taps 16,14,13,11 in right-shift Fibonacci form.
   assign lfsr_step_s = {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};

   // Zero-extended low bits of the LFSR below the table index.
   always_comb begin
      dither_s = '0;
      for (int i = 0; i < DITHER_W && i < 16; i++) begin
         dither_s[i] = lfsr_r[i];
      end
   end

   // LFSR advances once per accepted phasor.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= 16'hACE1;
      end else if (enable && accept_s) begin
         lfsr_r <= lfsr_step_s;
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign phase_dith_s = phase_r + dither_s;
`else
   assign phase_dith_s = phase_r;
`endif

   // Shift rather than slice so the truncated low phase bits stay visibly consumed.
   assign idx_s = IDX_W'(phase_dith_s >> DITHER_W);

   lfo_quarter_lut #(
      .G_LUT_ADDR_WIDTH (G_LUT_ADDR_WIDTH),
      .G_DOUT_WIDTH     (G_DOUT_WIDTH),
      .G_AMPLITUDE      (G_AMPLITUDE)
   ) u_lut (
      .clk     (clk),
      .reset_n (reset_n),
      .addr_a  (sin_addr_r),
      .addr_b  (cos_addr_r),
      .data_a  (t_sin_s),
      .data_b  (t_cos_s)
   );

   // Next-state and datapath decode; enable outranks sync_clear, which outranks acceptance.
   always_comb begin
      state_nxt    = state_r;
      phase_nxt    = phase_r;
      sin_addr_nxt = sin_addr_r;
      cos_addr_nxt = cos_addr_r;
      quad_nxt     = quad_r;
      re_nxt       = re_r;
      im_nxt       = im_r;
      valid_nxt    = valid_r;
      if (!enable) begin
         state_nxt = SM_INIT;
         valid_nxt = 1'b0;
      end else if (sync_clear) begin
         phase_nxt = '0;
         valid_nxt = 1'b0;
         state_nxt = SM_ADDR;
      end else begin
         case (state_r)
            SM_INIT: begin
               state_nxt = SM_ADDR;
            end
            SM_ADDR: begin
               quad_nxt     = idx_s[IDX_W-1 -: 2];
               sin_addr_nxt = {1'b0, idx_s[G_LUT_ADDR_WIDTH-1:0]};
               cos_addr_nxt = C_N_ADDR - {1'b0, idx_s[G_LUT_ADDR_WIDTH-1:0]};
               state_nxt    = SM_LUT;
            end
            SM_LUT: begin
               state_nxt = SM_MAP;
            end
            SM_MAP: begin
               case (quad_r)
                  2'd0: begin re_nxt =  t_cos_s; im_nxt =  t_sin_s; end
                  2'd1: begin re_nxt = -t_sin_s; im_nxt =  t_cos_s; end
                  2'd2: begin re_nxt = -t_cos_s; im_nxt = -t_sin_s; end
                  2'd3: begin re_nxt =  t_sin_s; im_nxt = -t_cos_s; end
                  default: begin re_nxt = '0; im_nxt = '0; end
               endcase
               valid_nxt = 1'b1;
               state_nxt = SM_SEND_OUTPUT;
            end
            SM_SEND_OUTPUT: begin
               if (accept_s) begin
                  phase_nxt = phase_r + phase_inc;
                  valid_nxt = 1'b0;
                  state_nxt = SM_ADDR;
               end else begin
                  state_nxt = SM_SEND_OUTPUT;
               end
            end
            default: begin
               valid_nxt = 1'b0;
               state_nxt = SM_INIT;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= SM_INIT;
         phase_r    <= '0;
         sin_addr_r <= '0;
         cos_addr_r <= '0;
         quad_r     <= 2'd0;
         re_r       <= '0;
         im_r       <= '0;
         valid_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         phase_r    <= phase_nxt;
         sin_addr_r <= sin_addr_nxt;
         cos_addr_r <= cos_addr_nxt;
         quad_r     <= quad_nxt;
         re_r       <= re_nxt;
         im_r       <= im_nxt;
         valid_r    <= valid_nxt;
      end
   end

   assign dout_re    = re_r;
   assign dout_im    = im_r;
   assign dout_valid = valid_r;

endmodule

// File: tb/tb_lfo_phasor_gen.sv
// Scoreboard bench for lfo_phasor_gen: directed scenarios plus a randomized run.
module tb_lfo_phasor_gen;

   localparam real PI = 3.14159265358979323846;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } pair_t;

   logic               clk;
   logic               reset_n;
   logic               enable;
   logic [31:0]        phase_inc;
   logic               sync_clear;
   logic signed [15:0] dout_re;
   logic signed [15:0] dout_im;
   logic               dout_valid;
   logic               dout_ready;

   pair_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   lfo_phasor_gen dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .phase_inc  (phase_inc),
      .sync_clear (sync_clear),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int rnd(input real x);
      if (x >= 0.0) return $rtoi(x + 0.5);
      else return -$rtoi(-x + 0.5);
   endfunction

   // Ideal unit phasor at the 10-bit truncated phase, scaled and rounded.
   function automatic pair_t model_out(input logic [31:0] ph);
      pair_t p;
      real   ang;
      ang  = 2.0 * PI * real'(int'(ph[31:22])) / 1024.0;
      p.re = 16'(rnd(32767.0 * $cos(ang)));
      p.im = 16'(rnd(32767.0 * $sin(ang)));
      return p;
   endfunction

   function automatic pair_t mk(input int re, input int im);
      pair_t p;
      p.re = 16'(re);
      p.im = 16'(im);
      return p;
   endfunction

   // Monitor: every accepted output is popped and compared.
   always @(negedge clk) begin
      if (reset_n && enable && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            pair_t e;
            e = exp_q.pop_front();
            check("dout_re", int'(dout_re), int'(e.re));
            check("dout_im", int'(dout_im), int'(e.im));
         end
      end
   end

   task automatic do_reset(input logic [31:0] inc, input logic rdy);
      reset_n    = 1'b0;
      enable     = 1'b1;
      sync_clear = 1'b0;
      dout_ready = rdy;
      phase_inc  = inc;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", int'(dout_valid), 0);
      check("reset_re", int'(dout_re), 0);
      check("reset_im", int'(dout_im), 0);
      reset_n = 1'b1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!dout_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!dout_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic accept_one(input logic clr, input int pre);
      wait_valid();
      repeat (pre) begin
         @(posedge clk);
         #1;
      end
      dout_ready = 1'b1;
      sync_clear = clr;
      @(posedge clk);
      #1;
      dout_ready = 1'b0;
      sync_clear = 1'b0;
   endtask

   task automatic check_drained(input string name);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int          prev;
      int          cnt;
      int          lat;
      logic [31:0] model_phase;
      logic [31:0] inc;
      logic        clr;

      reset_n = 1'b0; enable = 1'b1; sync_clear = 1'b0;
      dout_ready = 1'b0; phase_inc = '0;

      // Quarter turn with ready held high: values, first latency, spacing.
      do_reset(32'h4000_0000, 1'b1);
      exp_q.push_back(mk(32767, 0));
      exp_q.push_back(mk(0, 32767));
      exp_q.push_back(mk(-32767, 0));
      exp_q.push_back(mk(0, -32767));
      exp_q.push_back(mk(32767, 0));
      cnt = 0; prev = 0;
      for (int e = 1; e <= 21; e++) begin
         @(posedge clk);
         #1;
         if (dout_valid) begin
            if (cnt == 0) check("first_valid_edge", e, 4);
            else check("valid_spacing", e - prev, 4);
            prev = e;
            cnt++;
         end
      end
      dout_ready = 1'b0;
      check("quarter_count", cnt, 5);
      check_drained("quarter_drain");

      // Reverse rotation through wrap-around.
      do_reset(32'hC000_0000, 1'b0);
      exp_q.push_back(mk(32767, 0));
      exp_q.push_back(mk(0, -32767));
      exp_q.push_back(mk(-32767, 0));
      exp_q.push_back(mk(0, 32767));
      repeat (4) accept_one(1'b0, 0);
      check_drained("reverse_drain");

      // Backpressure: output held stable, phase does not skip.
      do_reset(32'h4000_0000, 1'b0);
      exp_q.push_back(mk(32767, 0));
      exp_q.push_back(mk(0, 32767));
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", int'(dout_valid), 1);
         check("bp_re", int'(dout_re), 32767);
         check("bp_im", int'(dout_im), 0);
      end
      accept_one(1'b0, 0);
      accept_one(1'b0, 0);
      check_drained("bp_drain");

      // sync_clear coincident with acceptance of (-32767, 0).
      do_reset(32'h4000_0000, 1'b0);
      exp_q.push_back(mk(32767, 0));
      exp_q.push_back(mk(0, 32767));
      exp_q.push_back(mk(-32767, 0));
      exp_q.push_back(mk(32767, 0));
      accept_one(1'b0, 0);
      accept_one(1'b0, 0);
      accept_one(1'b1, 1);
      accept_one(1'b0, 0);
      check_drained("clear_drain");

      // enable low for 3 cycles while in SM_LUT.
      do_reset(32'h4000_0000, 1'b0);
      exp_q.push_back(mk(32767, 0));
      exp_q.push_back(mk(0, 32767));
      accept_one(1'b0, 0);
      @(posedge clk);
      #1;
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("en_low_valid", int'(dout_valid), 0);
      end
      enable = 1'b1;
      lat = 0;
      for (int e = 1; e <= 12 && lat == 0; e++) begin
         @(posedge clk);
         #1;
         if (dout_valid) lat = e;
      end
      check("enable_resume_latency", lat, 4);
      accept_one(1'b0, 0);
      check_drained("enable_drain");

      // Asynchronous reset during SM_SEND_OUTPUT.
      do_reset(32'h4000_0000, 1'b0);
      exp_q.push_back(mk(32767, 0));
      wait_valid();
      check("pre_areset_valid", int'(dout_valid), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_valid", int'(dout_valid), 0);
      check("areset_re", int'(dout_re), 0);
      check("areset_im", int'(dout_im), 0);
      exp_q.delete();
      exp_q.push_back(mk(32767, 0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      accept_one(1'b0, 0);
      check_drained("areset_drain");

      // Randomized increments, backpressure and occasional clears.
      do_reset(32'h0, 1'b0);
      model_phase = '0;
      exp_q.push_back(model_out(model_phase));
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0:       inc = 32'h0;
            1:       inc = 32'($urandom_range(0, 4095)) << 22;
            default: inc = $urandom;
         endcase
         clr = ($urandom_range(0, 7) == 0);
         phase_inc = inc;
         accept_one(clr, $urandom_range(0, 3));
         model_phase = clr ? 32'h0 : model_phase + inc;
         exp_q.push_back(model_out(model_phase));
      end
      accept_one(1'b0, 0);
      check_drained("random_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
